// File: rtl/tilegame_pkg.sv
// tilegame_pkg: shared sizes, key indices, debounce state encoding and tile encoder for the tile game input path
package tilegame_pkg;
  localparam int NUM_KEYS = 4;
  localparam int NUM_SW = 10;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int KEY_QUIT = 0;
  localparam int KEY_BEGIN = 1;
  localparam int KEY_SEL1 = 2;
  localparam int KEY_SEL2 = 3;
  typedef enum logic [1:0] {IDLE_LO, WAIT_HI, HI, WAIT_LO} db_state_t;
  // Returns {valid, index}: valid only when exactly one bit is set, index forced to 0 otherwise.
  function automatic logic [4:0] tile_encode(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) idx = v[i] ? 4'(i) : idx;
    return ($countones(v) == 1) ? {1'b1, idx} : 5'd0;
  endfunction
endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: 2-flop synchronizer + 4-state debounce FSM for one input bit (clk, rst, din -> level, rise, fall)
module debounce_cell
  import tilegame_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  db_state_t state;
  // The counter is cleared on every state exit, so it never needs to wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      cnt <= '0;
      state <= IDLE_LO;
      level <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        IDLE_LO: if (sync[1]) begin
          state <= WAIT_HI;
          cnt <= CW'(1);
        end
        WAIT_HI: if (!sync[1]) begin
          state <= IDLE_LO;
          cnt <= '0;
        end else if (cnt == LAST) begin
          state <= HI;
          cnt <= '0;
          level <= 1'b1;
          rise <= 1'b1;
        end else cnt <= cnt + 1'b1;
        HI: if (!sync[1]) begin
          state <= WAIT_LO;
          cnt <= CW'(1);
        end
        WAIT_LO: if (sync[1]) begin
          state <= HI;
          cnt <= '0;
        end else if (cnt == LAST) begin
          state <= IDLE_LO;
          cnt <= '0;
          level <= 1'b0;
          fall <= 1'b1;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE_LO;
      endcase
    end
  end
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: debounces KEY/SW into clean levels, press/release pulses, switch-change pulse and one-hot tile index
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = tilegame_pkg::DEBOUNCE_CYCLES_DEFAULT,
  parameter int NUM_KEYS = tilegame_pkg::NUM_KEYS,
  parameter int NUM_SW = tilegame_pkg::NUM_SW
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] KEY,
  input  logic [NUM_SW-1:0]   SW,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_SW-1:0]   sw_stable,
  output logic                sw_change,
  output logic [3:0]          tile_sel,
  output logic                tile_valid
);
  import tilegame_pkg::*;
  logic [NUM_SW-1:0] sw_rise, sw_fall;
  // Keys are active-low; inverting ahead of the synchronizer makes 1 mean pressed everywhere inside.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
      .clk(CLOCK_50), .rst(reset), .din(~KEY[i]),
      .level(key_level[i]), .rise(key_press[i]), .fall(key_release[i])
    );
  end
  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
      .clk(CLOCK_50), .rst(reset), .din(SW[i]),
      .level(sw_stable[i]), .rise(sw_rise[i]), .fall(sw_fall[i])
    );
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sw_change <= 1'b0;
      {tile_valid, tile_sel} <= 5'd0;
    end else begin
      sw_change <= |{sw_rise, sw_fall};
      {tile_valid, tile_sel} <= tile_encode(16'(sw_stable));
    end
  end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed self-checking bench for input_conditioner with DEBOUNCE_CYCLES = 4
module tb_input_conditioner;
  import tilegame_pkg::*;
  logic clk, reset;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [3:0] key_level, key_press, key_release;
  logic [9:0] sw_stable;
  logic sw_change, tile_valid;
  logic [3:0] tile_sel;
  int n_cmp, n_err;

  input_conditioner #(.DEBOUNCE_CYCLES(4), .NUM_KEYS(4), .NUM_SW(10)) dut (
    .CLOCK_50(clk), .reset(reset), .KEY(KEY), .SW(SW),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .sw_stable(sw_stable), .sw_change(sw_change), .tile_sel(tile_sel), .tile_valid(tile_valid)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    KEY = '1;
    SW = '0;
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    KEY = '1;
    SW = '0;
    reset = 1;
    tick();
    n_cmp++;
    if ({key_level, key_press, key_release, sw_stable, sw_change, tile_valid, tile_sel} !== 28'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0", {key_level, key_press, key_release, sw_stable, sw_change, tile_valid, tile_sel});
    end
    reset = 0;
    for (int j = 1; j <= 8; j++) begin
      tick();
      n_cmp++;
      if ({key_level, key_press, key_release, sw_stable, sw_change, tile_valid, tile_sel} !== 28'd0) begin
        n_err++;
        $display("FAIL idle_after_reset t%0d: got %h want 0", j, {key_level, key_press, key_release, sw_stable, sw_change, tile_valid, tile_sel});
      end
    end
  endtask

  task automatic test_press_latency();
    logic [3:0] exp_p;
    do_reset();
    KEY[KEY_SEL1] = 0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      exp_p = (j == 6) ? 4'b0100 : 4'b0000;
      n_cmp++;
      if (key_press !== exp_p) begin
        n_err++;
        $display("FAIL latency_press t%0d: got %b want %b", j, key_press, exp_p);
      end
      n_cmp++;
      if (key_level !== ((j >= 6) ? 4'b0100 : 4'b0000)) begin
        n_err++;
        $display("FAIL latency_level t%0d: got %b want %b", j, key_level, (j >= 6) ? 4'b0100 : 4'b0000);
      end
      n_cmp++;
      if (key_release !== 4'b0000) begin
        n_err++;
        $display("FAIL latency_release t%0d: got %b want 0000", j, key_release);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    KEY[KEY_BEGIN] = 0;
    tick();
    tick();
    tick();
    KEY[KEY_BEGIN] = 1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      n_cmp++;
      if ({key_level, key_press, key_release} !== 12'd0) begin
        n_err++;
        $display("FAIL glitch t%0d: got %h want 000", j, {key_level, key_press, key_release});
      end
    end
  endtask

  task automatic test_press_release();
    int np, nr, tp, tr;
    np = 0; nr = 0; tp = -1; tr = -1;
    do_reset();
    KEY[KEY_QUIT] = 0;
    for (int j = 1; j <= 26; j++) begin
      tick();
      if (key_press[0]) begin np++; tp = j; end
      if (key_release[0]) begin nr++; tr = j; end
      if (j == 10) KEY[KEY_QUIT] = 1;
    end
    n_cmp++;
    if (np !== 1) begin n_err++; $display("FAIL pr_press_count: got %0d want 1", np); end
    n_cmp++;
    if (nr !== 1) begin n_err++; $display("FAIL pr_release_count: got %0d want 1", nr); end
    n_cmp++;
    if (tp !== 6) begin n_err++; $display("FAIL pr_press_time: got %0d want 6", tp); end
    n_cmp++;
    if (tr !== 16) begin n_err++; $display("FAIL pr_release_time: got %0d want 16", tr); end
    n_cmp++;
    if (key_level[0] !== 1'b0) begin n_err++; $display("FAIL pr_final_level: got %b want 0", key_level[0]); end
  endtask

  task automatic test_reset_mid_debounce();
    do_reset();
    KEY[KEY_SEL2] = 0;
    tick();
    tick();
    reset = 1;
    for (int j = 1; j <= 3; j++) begin
      tick();
      n_cmp++;
      if ({key_level, key_press, key_release, sw_stable, sw_change, tile_valid, tile_sel} !== 28'd0) begin
        n_err++;
        $display("FAIL midreset_outputs t%0d: got %h want 0", j, {key_level, key_press, key_release, sw_stable, sw_change, tile_valid, tile_sel});
      end
    end
    reset = 0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      n_cmp++;
      if (key_press !== ((j == 6) ? 4'b1000 : 4'b0000)) begin
        n_err++;
        $display("FAIL midreset_press t%0d: got %b want %b", j, key_press, (j == 6) ? 4'b1000 : 4'b0000);
      end
    end
    n_cmp++;
    if (key_level !== 4'b1000) begin n_err++; $display("FAIL midreset_level: got %b want 1000", key_level); end
  endtask

  task automatic test_switches();
    do_reset();
    SW = 10'b0000100000;
    for (int j = 1; j <= 12; j++) begin
      tick();
      n_cmp++;
      if (sw_stable !== ((j >= 6) ? 10'b0000100000 : 10'b0)) begin
        n_err++;
        $display("FAIL sw_stable_a t%0d: got %b want %b", j, sw_stable, (j >= 6) ? 10'b0000100000 : 10'b0);
      end
      n_cmp++;
      if ({sw_change, tile_valid, tile_sel} !== {j == 7, j >= 7, (j >= 7) ? 4'd5 : 4'd0}) begin
        n_err++;
        $display("FAIL sw_tile_a t%0d: got %b want %b", j, {sw_change, tile_valid, tile_sel}, {j == 7, j >= 7, (j >= 7) ? 4'd5 : 4'd0});
      end
    end
    SW[7] = 1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      n_cmp++;
      if (sw_stable !== ((j >= 6) ? 10'b0010100000 : 10'b0000100000)) begin
        n_err++;
        $display("FAIL sw_stable_b t%0d: got %b want %b", j, sw_stable, (j >= 6) ? 10'b0010100000 : 10'b0000100000);
      end
      n_cmp++;
      if ({sw_change, tile_valid, tile_sel} !== {j == 7, j < 7, (j < 7) ? 4'd5 : 4'd0}) begin
        n_err++;
        $display("FAIL sw_tile_b t%0d: got %b want %b", j, {sw_change, tile_valid, tile_sel}, {j == 7, j < 7, (j < 7) ? 4'd5 : 4'd0});
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    KEY = 4'b0011;
    for (int j = 1; j <= 10; j++) begin
      tick();
      n_cmp++;
      if (key_press !== ((j == 6) ? 4'b1100 : 4'b0000)) begin
        n_err++;
        $display("FAIL simul_press t%0d: got %b want %b", j, key_press, (j == 6) ? 4'b1100 : 4'b0000);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1;
    KEY = '1;
    SW = '0;
    test_reset();
    test_press_latency();
    test_glitch();
    test_press_release();
    test_reset_mid_debounce();
    test_switches();
    test_simultaneous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
